// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the memory-mapped UART transmitter.
package uart_pkg;

   localparam logic [3:0] OFF_TXDATA = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_RSVD0  = 4'h8;
   localparam logic [3:0] OFF_RSVD1  = 4'hC;

   localparam int unsigned STATUS_BUSY  = 0;
   localparam int unsigned STATUS_FULL  = 1;
   localparam int unsigned STATUS_EMPTY = 2;

   typedef enum logic {
      BUS_IDLE,
      BUS_RESP
   } bus_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// PicoRV32 native memory bus as seen by the UART transmitter.
interface mmio_uart_tx_if;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with combinational head read; the extra pointer bit
// distinguishes full from empty after wrap-around.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata   = mem[rd_ptr[AW-1:0]];
   // A pop in the same cycle frees the head slot, so a push on full is legal then.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the PicoRV32 native bus.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   mmio_uart_tx_if.slave bus,
   output logic          uart_tx
);

   localparam int unsigned       BAUD_W    = $clog2(CLK_DIV);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("CLK_DIV must be at least 2");
   end
   if (FIFO_DEPTH < 2) begin : g_bad_fifo_depth
      $error("FIFO_DEPTH must be at least 2");
   end

   bus_state_t        bus_state, bus_next;
   tx_state_t         tx_state, tx_next;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic              baud_end;
   logic              tx_line;

   logic              q_push, q_pop, q_full, q_empty;
   logic [7:0]        q_head;

   logic [3:0]        offset;
   logic              sel, txdata_wr, stall, accept;
   logic [31:0]       reg_val;
   logic              unused_bus_bits;

   assign offset    = bus.mem_addr[3:0];
   assign sel       = bus.mem_valid && (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
   assign txdata_wr = sel && (offset == OFF_TXDATA) && bus.mem_wstrb[0];
   assign stall     = txdata_wr && q_full && !q_pop;
   assign q_push    = accept && txdata_wr;
   assign baud_end  = (baud_cnt == BAUD_LAST);
   assign unused_bus_bits = ^{bus.mem_wdata[31:8], bus.mem_wstrb[3:1]};

   always_comb begin
      reg_val = '0;
      if (offset == OFF_STATUS) begin
         reg_val[STATUS_BUSY]  = (tx_state != TX_IDLE);
         reg_val[STATUS_FULL]  = q_full;
         reg_val[STATUS_EMPTY] = q_empty && (tx_state == TX_IDLE);
      end
   end

   // Bus responder FSM
   always_comb begin
      bus_next = bus_state;
      accept   = 1'b0;
      case (bus_state)
         BUS_IDLE: begin
            if (sel && !stall) begin
               accept   = 1'b1;
               bus_next = BUS_RESP;
            end
         end
         BUS_RESP: bus_next = BUS_IDLE;
         default:  bus_next = BUS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus_state     <= BUS_IDLE;
         bus.mem_rdata <= '0;
      end else begin
         bus_state <= bus_next;
         if (accept) bus.mem_rdata <= reg_val;
      end
   end

   assign bus.mem_ready = (bus_state == BUS_RESP);

   // TX FSM; STOP chains straight into START when more data is queued
   always_comb begin
      tx_next = tx_state;
      q_pop   = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (!q_empty) begin
               q_pop   = 1'b1;
               tx_next = TX_START;
            end
         end
         TX_START: if (baud_end) tx_next = TX_DATA;
         TX_DATA:  if (baud_end && bit_idx == 3'd7) tx_next = TX_STOP;
         TX_STOP: begin
            if (baud_end) begin
               if (!q_empty) begin
                  q_pop   = 1'b1;
                  tx_next = TX_START;
               end else begin
                  tx_next = TX_IDLE;
               end
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      case (tx_state)
         TX_START: tx_line = 1'b0;
         TX_DATA:  tx_line = shreg[0];
         default:  tx_line = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state <= TX_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         uart_tx  <= 1'b1;
      end else begin
         tx_state <= tx_next;
         if (tx_next != tx_state || baud_end) begin
            baud_cnt <= '0;
         end else if (tx_state != TX_IDLE) begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
         end
         if (q_pop) begin
            shreg <= q_head;
         end else if (tx_state == TX_DATA && baud_end) begin
            shreg <= {1'b0, shreg[7:1]};
         end
         if (tx_state == TX_DATA && baud_end) bit_idx <= bit_idx + 3'd1;
         uart_tx <= tx_line;
      end
   end

`ifdef UART_TX_FIFO_EN
   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (q_push),
      .pop     (q_pop),
      .wdata   (bus.mem_wdata[7:0]),
      .rdata   (q_head),
      .full    (q_full),
      .empty   (q_empty)
   );
`else
   logic       hold_valid;
   logic [7:0] hold_data;

   // Push wins over pop so a write landing on the popping cycle stays queued.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (q_push) begin
         hold_valid <= 1'b1;
         hold_data  <= bus.mem_wdata[7:0];
      end else if (q_pop) begin
         hold_valid <= 1'b0;
      end
   end

   assign q_full  = hold_valid;
   assign q_empty = !hold_valid;
   assign q_head  = hold_data;
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register table plus frame, stall and reset sequences.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int          DIV  = 4;
`ifdef UART_TX_FIFO_EN
   localparam int          QD   = 2;
`else
   localparam int          QD   = 1;
`endif

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic uart_tx;
   int   cyc     = 0;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   mmio_uart_tx_if bus ();

   mmio_uart_tx #(
      .BASE_ADDR  (BASE),
      .CLK_DIV    (DIV),
      .FIFO_DEPTH (2)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .uart_tx (uart_tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        exp_ready;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int limit, output logic got_ready, output logic [31:0] rdata,
                           output int lat, output int resp_cyc);
      int n;
      n         = 0;
      got_ready = 1'b0;
      rdata     = '0;
      resp_cyc  = -1;
      @(negedge clk);
      bus.mem_valid = 1'b1;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
      bus.mem_wstrb = wstrb;
      while (!got_ready && n < limit) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.mem_ready === 1'b1) begin
            got_ready = 1'b1;
            rdata     = bus.mem_rdata;
            resp_cyc  = cyc;
         end
      end
      lat           = n;
      bus.mem_valid = 1'b0;
      bus.mem_wstrb = '0;
      if (got_ready) begin
         @(posedge clk);
         #1;
         check("ready_one_cycle", {31'b0, bus.mem_ready}, 32'h0);
      end
   endtask

   task automatic rx_frame(input int limit, output logic [7:0] data, output int t_start, output logic ok);
      logic [9:0] bits;
      logic       first;
      int         n;
      n       = 0;
      ok      = 1'b1;
      data    = '0;
      bits    = '0;
      t_start = -1;
      while (uart_tx !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (uart_tx !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      t_start = cyc;
      for (int b = 0; b < 10; b++) begin
         first = uart_tx;
         for (int k = 0; k < DIV; k++) begin
            if (uart_tx !== first) ok = 1'b0;
            @(negedge clk);
         end
         bits[b] = first;
      end
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
      data = bits[8:1];
   endtask

   logic        w_rdy, r_ok, r_ok2;
   logic [31:0] w_rd;
   int          w_lat, w_cyc, c_first, c_last, ts1, ts2, low_cnt;
   logic [7:0]  r_data, r_data2;
   logic [7:0]  stall_bytes [4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{BASE + 32'h4,  32'h0,         4'h0, 1'b1, 32'h4};
      vecs[1]  = '{BASE + 32'h0,  32'h0,         4'h0, 1'b1, 32'h0};
      vecs[2]  = '{BASE + 32'h8,  32'h0,         4'h0, 1'b1, 32'h0};
      vecs[3]  = '{BASE + 32'hC,  32'h0,         4'h0, 1'b1, 32'h0};
      vecs[4]  = '{BASE + 32'h8,  32'hFF,        4'hF, 1'b1, 32'h0};
      vecs[5]  = '{BASE + 32'h4,  32'hFFFF_FFFF, 4'hF, 1'b1, 32'h4};
      vecs[6]  = '{BASE + 32'h0,  32'h41,        4'h2, 1'b1, 32'h0};
      vecs[7]  = '{32'h2000_0004, 32'h0,         4'h0, 1'b0, 32'h0};
      vecs[8]  = '{BASE + 32'h10, 32'h41,        4'hF, 1'b0, 32'h0};
      vecs[9]  = '{32'h0000_0000, 32'h41,        4'h1, 1'b0, 32'h0};
      vecs[10] = '{BASE + 32'h4,  32'h0,         4'h0, 1'b1, 32'h4};
      stall_bytes[0] = 8'h11;
      stall_bytes[1] = 8'h22;
      stall_bytes[2] = 8'h33;
      stall_bytes[3] = 8'h44;

      bus.mem_valid = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wstrb = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
      check("rst_ready", {31'b0, bus.mem_ready}, 32'h0);
      check("rst_rdata", bus.mem_rdata, 32'h0);
      reset_n = 1'b1;

      // Register window table
      for (int i = 0; i < 11; i++) begin
         bus_xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 20, w_rdy, w_rd, w_lat, w_cyc);
         check($sformatf("vec%0d_ready", i), {31'b0, w_rdy}, {31'b0, vecs[i].exp_ready});
         if (vecs[i].exp_ready) begin
            check($sformatf("vec%0d_rdata", i), w_rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_latency", i), 32'(w_lat), 32'd1);
         end
      end
      check("idle_line_after_table", {31'b0, uart_tx}, 32'h1);

      // Single byte, TX latency and mid-frame status
      fork
         begin
            bus_xfer(BASE, 32'h41, 4'h1, 20, w_rdy, w_rd, w_lat, w_cyc);
            c_first = w_cyc;
            check("single_wr_ready", {31'b0, w_rdy}, 32'h1);
            repeat (10) @(negedge clk);
            bus_xfer(BASE + 32'h4, 32'h0, 4'h0, 20, w_rdy, w_rd, w_lat, w_cyc);
            check("status_midframe", w_rd, 32'h1);
         end
         rx_frame(200, r_data, ts1, r_ok);
      join
      check("single_frame_ok", {31'b0, r_ok}, 32'h1);
      check("single_frame_data", {24'b0, r_data}, 32'h41);
      check("tx_latency", 32'(ts1 - c_first), 32'd2);
      bus_xfer(BASE + 32'h4, 32'h0, 4'h0, 20, w_rdy, w_rd, w_lat, w_cyc);
      check("status_after_frame", w_rd, 32'h4);

      // Back-to-back frames
      fork
         begin
            bus_xfer(BASE, 32'h55, 4'h1, 20, w_rdy, w_rd, w_lat, w_cyc);
            bus_xfer(BASE, 32'hAA, 4'h1, 20, w_rdy, w_rd, w_lat, w_cyc);
         end
         begin
            rx_frame(200, r_data, ts1, r_ok);
            rx_frame(200, r_data2, ts2, r_ok2);
         end
      join
      check("b2b_ok", {30'b0, r_ok, r_ok2}, 32'h3);
      check("b2b_data", {16'b0, r_data, r_data2}, 32'h55AA);
      check("b2b_gap", 32'(ts2 - ts1), 32'd40);
      check("b2b_total", 32'(cyc - ts1), 32'd80);

      // Queue-full stall released by the first frame's pop
      fork
         begin
            for (int i = 0; i < QD + 2; i++) begin
               bus_xfer(BASE, {24'b0, stall_bytes[i]}, 4'h1, 200, w_rdy, w_rd, w_lat, w_cyc);
               check("stall_wr_ready", {31'b0, w_rdy}, 32'h1);
               if (i == 0) c_first = w_cyc;
               c_last = w_cyc;
            end
         end
         begin
            for (int i = 0; i < QD + 2; i++) begin
               rx_frame(400, r_data, ts1, r_ok);
               check("stall_frame_ok", {31'b0, r_ok}, 32'h1);
               check($sformatf("stall_byte%0d", i), {24'b0, r_data}, {24'b0, stall_bytes[i]});
            end
         end
      join
      check("stall_release_cycle", 32'(c_last - c_first), 32'd41);

      // Reset during DATA
      bus_xfer(BASE, 32'h5A, 4'h1, 20, w_rdy, w_rd, w_lat, w_cyc);
      c_first = w_cyc;
      bus_xfer(BASE, 32'hC3, 4'h1, 20, w_rdy, w_rd, w_lat, w_cyc);
      while (cyc < c_first + 8) @(negedge clk);
      check("pre_reset_line", {31'b0, uart_tx}, 32'h0);
      #2 reset_n = 1'b0;
      #1;
      check("reset_line_high", {31'b0, uart_tx}, 32'h1);
      check("reset_ready_low", {31'b0, bus.mem_ready}, 32'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      bus_xfer(BASE + 32'h4, 32'h0, 4'h0, 20, w_rdy, w_rd, w_lat, w_cyc);
      check("status_after_reset", w_rd, 32'h4);
      low_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) low_cnt++;
      end
      check("no_residual_tx", 32'(low_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that acts as a responder on the PicoRV32 native memory interface. The CPU, or a testbench initiator, writes bytes and reads status through it. It decodes a small register window, queues written bytes, and serialises them as 8N1 on `uart_tx`. It sits beside `bram_controller` on the same bus, behind the system address decode.

## Interface
- `BASE_ADDR`, default `32'h1000_0000`: base of the 16-byte register window; bits [3:0] must be 0.
- `CLK_DIV`, default `868`: clocks per serial bit; minimum 2.
- `FIFO_DEPTH`, default `16`: TX queue entries; power of two, minimum 2. Used only when `UART_TX_FIFO_EN` is defined.
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `mem_valid`, in, 1: initiator request valid.
- `mem_addr`, in, 32: byte address.
- `mem_wdata`, in, 32: write data.
- `mem_wstrb`, in, 4: byte strobes; `4'b0000` means read.
- `mem_ready`, out, 1: response strobe.
- `mem_rdata`, out, 32: read data; valid while `mem_ready` is 1.
- `uart_tx`, out, 1: serial output, idle high.

## Operation
- **Select:** `mem_valid && mem_addr[31:4] == BASE_ADDR[31:4]`. Unselected requests are ignored; `mem_ready` stays 0.
- **Register map (offset = `mem_addr[3:0]`):**
  - `0x0` TXDATA, write-only: a write with `mem_wstrb[0]=1` enqueues `mem_wdata[7:0]`. Reads return 0.
  - `0x4` STATUS, read-only: bit0 `busy` (shifter not idle), bit1 `full`, bit2 `empty` (queue empty and shifter idle). Other bits are 0.
  - `0x8`, `0xC`: reads return 0; writes are accepted and discarded.
- **Bus FSM:**
  - IDLE → RESP when the request is selected, unless it is a TXDATA write while the queue is full. In that case stay in IDLE with `mem_ready=0`, stalling until space frees.
  - RESP: `mem_ready=1` for exactly one cycle. `mem_rdata` holds the register value sampled on entry. The enqueue is performed on the IDLE→RESP edge. RESP → IDLE unconditionally.
  - In the cycle after RESP, the initiator must drop `mem_valid` or present a new request. A selected `mem_valid` seen in IDLE is always a new transaction.
- **TX FSM:** IDLE, START, DATA, STOP.
  - IDLE pops the queue when it is non-empty.
  - START drives 0 for `CLK_DIV` clocks.
  - DATA sends 8 bits LSB first, `CLK_DIV` clocks each. A 3-bit index wraps 7 → STOP.
  - STOP drives 1 for `CLK_DIV` clocks, then returns to IDLE. If the queue is non-empty, the next START begins on the following cycle with no extra idle bit.
- **Baud counter:** `$clog2(CLK_DIV)` bits; counts 0..`CLK_DIV-1` and is cleared on every state transition.
- **Simultaneous enqueue and pop on a full queue:** the pop frees a slot in the same cycle, so the write is accepted without a stall.

## Timing
- **Reset values:** `mem_ready=0`, `mem_rdata=0`, `uart_tx=1`; both FSMs in IDLE; queue empty; all counters 0.
- **Bus latency:** `mem_ready` rises one cycle after a selected, non-stalled `mem_valid` is sampled.
- **TX latency:** a write to an idle block drives `uart_tx` low 2 cycles after the write's RESP cycle (enqueue → pop → START).
- **Frame length:** exactly `10*CLK_DIV` clocks.
- **Reset asserted mid-frame:** `uart_tx` goes to 1 immediately; the queue and any pending bus response are discarded.

## Configuration
- **`UART_TX_FIFO_EN` defined:** the queue is a `FIFO_DEPTH`-entry FIFO.
- **Not defined:** the queue is a single holding register (depth 1). `full` equals the holding register being occupied, and `FIFO_DEPTH` is ignored. Register map and timing are otherwise identical.

## Structure
- **Package `uart_pkg`:** register offset constants, STATUS bit positions, and enums for the bus FSM and TX FSM states.
- **Sub-module `uart_tx_fifo`:**
  - Synchronous FIFO with push/pop/full/empty.
  - Read data is available combinationally at the head.
  - Pointers are `$clog2(FIFO_DEPTH)+1` bits, so that wrap-around distinguishes full from empty.
  - `mmio_uart_tx` instantiates it only under `UART_TX_FIFO_EN`.

## Test plan
- **Reset state:** release reset, read STATUS → `mem_rdata=32'h4`, `uart_tx=1`, `mem_ready` asserted exactly one cycle.
- **Single byte:** write `32'h41` to TXDATA with `CLK_DIV=4` → `uart_tx` emits 0, 1,0,0,0,0,0,1,0, 1, each held 4 clocks. STATUS reads busy=1 mid-frame and `32'h4` after the frame.
- **Back-to-back:** write `0x55` then `0xAA` → two frames with no idle gap, 80 clocks total at `CLK_DIV=4`.
- **Full stall:** with `UART_TX_FIFO_EN` and `FIFO_DEPTH=2`, issue 4 writes → the 4th write's `mem_ready` is delayed until the first frame's pop; all 4 bytes appear in order.
- **Address decode:** read offset `0x8` → `mem_rdata=0`. A request outside `BASE_ADDR` → no `mem_ready` for 20 cycles.
- **Reset mid-frame:** assert `reset_n=0` during DATA → `uart_tx=1` immediately; after release, STATUS reads `32'h4` and no residual bytes are sent.
